frame_downsampler: RTL and testbench
====================================

Name: frame_downsampler

Overview:
- Downstream of the sync/geometry stage, in the HDMI pixel clock domain.
- Consumes row/frame strobes, measured image width/height and the aligned RGB pixel stream.
- Nearest-neighbour decimates each frame to the LED matrix resolution (OUT_W x OUT_H) using divider-free step accumulators.
- Emits one write per matrix pixel into the frame buffer, plus a frame-complete pulse.

Parameters:
- MAX_WIDTH, 1920, maximum input width; sets the width of I_image_width.
- MAX_HEIGHT, 1080, maximum input height; sets the width of I_image_height.
- OUT_W, 16, output matrix columns; must be >= 1.
- OUT_H, 8, output matrix rows; must be >= 1.
- COLOR_W, 24, pixel data width.

Ports:
- I_rgb_clk  in  1  pixel clock; the only clock.
- I_rst  in  1  synchronous reset, active-high.
- I_rgb_de  in  1  data enable, aligned with I_rgb_data.
- I_rgb_data  in  COLOR_W  pixel value.
- I_new_row  in  1  one-cycle row-start strobe.
- I_new_frame  in  1  one-cycle frame-start strobe.
- I_image_width  in  $clog2(MAX_WIDTH)  measured active width.
- I_image_height  in  $clog2(MAX_HEIGHT)  measured active height.
- I_width_valid  in  1  width measurement valid.
- I_height_valid  in  1  height measurement valid.
- O_wr_en  out  1  buffer write strobe.
- O_wr_addr  out  $clog2(OUT_W*OUT_H)  buffer address.
- O_wr_data  out  COLOR_W  sampled pixel.
- O_frame_done  out  1  one-cycle pulse after the last write of a frame.
- O_dims_err  out  1  latched dimensions are unusable.
- O_active  out  1  high while in S_ACTIVE.

Behaviour:
- Reset (I_rst=1 at a clock edge): state=S_WAIT_FRAME, all accumulators/counters 0, all outputs 0. Reset mid-frame discards the frame; no partial frame_done.
- Dimension check: performed on every I_new_frame.
  - Latch W=I_image_width, H=I_image_height.
  - Accept iff both valids=1, W>=OUT_W and H>=OUT_H.
  - Accept -> S_ACTIVE, O_dims_err=0.
  - Reject -> S_WAIT_FRAME, O_dims_err=1, no writes this frame.
  - Dimension changes between strobes are ignored.
- Frame start: on I_new_frame, clear acc_x, acc_y, out_x, out_y, write address and the frame-complete flag. A DE pixel in the same cycle as I_new_frame is ignored.
- Row qualification, evaluated on the first DE cycle of each row (DE rising edge) in S_ACTIVE:
  - sy = acc_y + OUT_H.
  - If sy >= H: row_sel=1 and acc_y=sy-H; otherwise row_sel=0 and acc_y=sy.
  - row_sel holds for the whole row.
  - I_new_row clears acc_x and out_x.
  - Rows without DE do not touch acc_y.
- Column sampling, on every DE cycle of the row, first DE cycle included:
  - sx = acc_x + OUT_W.
  - If sx >= W: hit and acc_x=sx-W; otherwise acc_x=sx.
  - A write is issued when hit and row_sel are both 1.
  - Rows with row_sel=0 still advance acc_x.
  - Yields exactly OUT_W hits per row and OUT_H selected rows per frame.
- Accumulators are $clog2(MAX_WIDTH+OUT_W)+1 bits wide, so sx never overflows.
- Write timing:
  - Latency is 1 cycle: O_wr_en is registered high the cycle after the sampled DE cycle, with O_wr_data = that cycle's I_rgb_data.
  - O_wr_addr = out_y*OUT_W + out_x, subject to the optional feature.
  - out_x increments per write. When out_x reaches OUT_W, further hits in the row are suppressed, and out_y increments at the next selected row.
- Frame completion:
  - The write with out_y=OUT_H-1, out_x=OUT_W-1 sets the complete flag.
  - O_frame_done pulses in the cycle after that write (one cycle after its O_wr_en).
  - Further writes are suppressed until the next I_new_frame.
- Truncated frame: I_new_frame before completion restarts at address 0; no frame_done.
- O_wr_en, O_frame_done: one-cycle pulses.
- O_dims_err: level, updated only on I_new_frame.

Optional Feature:
- Macro: FRAME_DOWNSAMPLER_SERPENTINE_EN.
- Defined: serpentine addressing for zig-zag LED chains. Odd out_y rows use O_wr_addr = out_y*OUT_W + (OUT_W-1-out_x); even rows are unchanged.
- Undefined: linear row-major addressing only.

Test Plan:
- OUT 16x8, W=32, H=16, pixel = {y,x}: x=1,3,…,31 sampled on rows y=1,3,…,15. 128 writes, addr 0..127 in order, addr 0 data = pixel (1,1), one frame_done the cycle after the addr-127 write.
- W=16, H=8: every pixel written; addr = y*16+x; each write 1 cycle after its DE.
- W=24, H=8: per row, sampled x = 1,2,4,5,7,8,…,22,23 (16 hits); 128 writes total.
- I_width_valid=0, or W=10 on I_new_frame: O_dims_err=1, O_active=0, zero writes. Next frame with W=32, H=16 valid: O_dims_err=0, normal output.
- I_rst=1 after 40 writes, then a new frame: outputs 0 during reset, no frame_done; the new frame restarts at addr 0.
- Serpentine macro defined, W=16, H=8: row 1, x=0 -> addr 31; row 1, x=15 -> addr 16; row 0 linear.

Source files
------------

// File: rtl/frame_downsampler.sv
`default_nettype none
// ============================================================================
//  Module   : frame_downsampler
//  Function : Nearest-neighbour decimation of the HDMI pixel stream down to
//             the LED matrix resolution (OUT_W x OUT_H). It uses add/compare
//             step accumulators instead of dividers. It issues one frame-buffer
//             write per matrix pixel and a frame-complete pulse.
//  Options  : FRAME_DOWNSAMPLER_SERPENTINE_EN - odd matrix rows are addressed
//             right-to-left to suit zig-zag LED chains.
//  Revision : 1.0 - initial release
// ============================================================================
module frame_downsampler #(
  parameter int MAX_WIDTH  = 1920,
  parameter int MAX_HEIGHT = 1080,
  parameter int OUT_W      = 16,
  parameter int OUT_H      = 8,
  parameter int COLOR_W    = 24
) (
  input  logic                           I_rgb_clk,
  input  logic                           I_rst,
  input  logic                           I_rgb_de,
  input  logic [COLOR_W-1:0]             I_rgb_data,
  input  logic                           I_new_row,
  input  logic                           I_new_frame,
  input  logic [$clog2(MAX_WIDTH)-1:0]   I_image_width,
  input  logic [$clog2(MAX_HEIGHT)-1:0]  I_image_height,
  input  logic                           I_width_valid,
  input  logic                           I_height_valid,
  output logic                           O_wr_en,
  output logic [$clog2(OUT_W*OUT_H)-1:0] O_wr_addr,
  output logic [COLOR_W-1:0]             O_wr_data,
  output logic                           O_frame_done,
  output logic                           O_dims_err,
  output logic                           O_active
);

  localparam int WW  = $clog2(MAX_WIDTH);
  localparam int HW  = $clog2(MAX_HEIGHT);
  localparam int AW  = $clog2(OUT_W*OUT_H);
  localparam int XAW = $clog2(MAX_WIDTH + OUT_W) + 1;   // sx = acc_x + OUT_W never overflows
  localparam int YAW = $clog2(MAX_HEIGHT + OUT_H) + 1;
  localparam int OXW = $clog2(OUT_W + 1);               // out_x must be able to hold OUT_W
  localparam int OYW = $clog2(OUT_H + 1);

  typedef enum logic [0:0] {
    S_WAIT_FRAME = 1'b0,
    S_ACTIVE     = 1'b1
  } state_t;

  state_t               state_q,      state_d;
  logic [WW-1:0]        w_q,          w_d;
  logic [HW-1:0]        h_q,          h_d;
  logic                 dims_err_q,   dims_err_d;
  logic [XAW-1:0]       acc_x_q,      acc_x_d;
  logic [YAW-1:0]       acc_y_q,      acc_y_d;
  logic [OXW-1:0]       out_x_q,      out_x_d;
  logic [OYW-1:0]       out_y_q,      out_y_d;
  logic                 row_sel_q,    row_sel_d;
  logic                 row_pend_q,   row_pend_d;   // a full row was written; advance out_y at next selected row
  logic                 complete_q,   complete_d;
  logic                 de_q,         de_d;
  logic                 wr_en_q,      wr_en_d;
  logic [AW-1:0]        wr_addr_q,    wr_addr_d;
  logic [COLOR_W-1:0]   wr_data_q,    wr_data_d;
  logic                 last_q,       last_d;       // the write in flight is the final one of the frame
  logic                 frame_done_q, frame_done_d;

  logic                 w_accept;
  logic [XAW-1:0]       w_sx;
  logic [YAW-1:0]       w_sy;
  logic                 w_sel;
  logic                 w_hit;
  logic [OXW-1:0]       w_ox;
  logic [OYW-1:0]       w_oy;

  // Buffer address of matrix pixel (oy, ox), optionally zig-zagged on odd rows.
  function automatic logic [AW-1:0] pix_addr(input logic [OYW-1:0] oy, input logic [OXW-1:0] ox);
    logic [31:0] col;
    col = 32'(ox);
`ifdef FRAME_DOWNSAMPLER_SERPENTINE_EN
    if (oy[0]) col = 32'(OUT_W - 1) - 32'(ox);
`endif
    return AW'(32'(oy) * 32'(OUT_W) + col);
  endfunction

  // Next-state: frame check, row qualification, column sampling and write issue.
  always_comb begin
    state_d      = state_q;
    w_d          = w_q;
    h_d          = h_q;
    dims_err_d   = dims_err_q;
    acc_x_d      = acc_x_q;
    acc_y_d      = acc_y_q;
    out_x_d      = out_x_q;
    out_y_d      = out_y_q;
    row_sel_d    = row_sel_q;
    row_pend_d   = row_pend_q;
    complete_d   = complete_q;
    de_d         = I_rgb_de;
    wr_en_d      = 1'b0;
    wr_addr_d    = '0;
    wr_data_d    = '0;
    last_d       = 1'b0;
    frame_done_d = wr_en_q & last_q;
    w_accept     = I_width_valid && I_height_valid &&
                   (XAW'(I_image_width)  >= XAW'(OUT_W)) &&
                   (YAW'(I_image_height) >= YAW'(OUT_H));
    w_sx         = '0;
    w_sy         = '0;
    w_sel        = row_sel_q;
    w_hit        = 1'b0;
    w_ox         = out_x_q;
    w_oy         = out_y_q;

    if (I_new_frame) begin
      // Geometry is only trusted at the frame strobe; any DE in this cycle is dropped.
      w_d        = I_image_width;
      h_d        = I_image_height;
      state_d    = w_accept ? S_ACTIVE : S_WAIT_FRAME;
      dims_err_d = ~w_accept;
      acc_x_d    = '0;
      acc_y_d    = '0;
      out_x_d    = '0;
      out_y_d    = '0;
      row_sel_d  = 1'b0;
      row_pend_d = 1'b0;
      complete_d = 1'b0;
    end else begin
      if (I_new_row) begin
        acc_x_d = '0;
        out_x_d = '0;
      end
      w_ox = out_x_d;
      if (state_q == S_ACTIVE && I_rgb_de) begin
        if (!de_q) begin
          // First DE cycle of a row decides whether the whole row is sampled.
          w_sy = acc_y_q + YAW'(OUT_H);
          if (w_sy >= YAW'(h_q)) begin
            w_sel   = 1'b1;
            acc_y_d = w_sy - YAW'(h_q);
          end else begin
            w_sel   = 1'b0;
            acc_y_d = w_sy;
          end
          row_sel_d = w_sel;
          if (w_sel && row_pend_q) begin
            w_oy       = out_y_q + OYW'(1);
            out_y_d    = w_oy;
            row_pend_d = 1'b0;
            w_ox       = '0;
            out_x_d    = '0;
          end
        end
        w_sx  = acc_x_d + XAW'(OUT_W);
        w_hit = (w_sx >= XAW'(w_q));
        acc_x_d = w_hit ? (w_sx - XAW'(w_q)) : w_sx;
        if (w_hit && w_sel && !complete_q && (w_ox < OXW'(OUT_W))) begin
          wr_en_d   = 1'b1;
          wr_data_d = I_rgb_data;
          wr_addr_d = pix_addr(w_oy, w_ox);
          out_x_d   = w_ox + OXW'(1);
          if (w_ox == OXW'(OUT_W - 1)) begin
            row_pend_d = 1'b1;
            if (w_oy == OYW'(OUT_H - 1)) begin
              complete_d = 1'b1;
              last_d     = 1'b1;
            end
          end
        end
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge I_rgb_clk) begin
    if (I_rst) begin
      state_q      <= S_WAIT_FRAME;
      w_q          <= '0;
      h_q          <= '0;
      dims_err_q   <= 1'b0;
      acc_x_q      <= '0;
      acc_y_q      <= '0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      row_sel_q    <= 1'b0;
      row_pend_q   <= 1'b0;
      complete_q   <= 1'b0;
      de_q         <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      last_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      w_q          <= w_d;
      h_q          <= h_d;
      dims_err_q   <= dims_err_d;
      acc_x_q      <= acc_x_d;
      acc_y_q      <= acc_y_d;
      out_x_q      <= out_x_d;
      out_y_q      <= out_y_d;
      row_sel_q    <= row_sel_d;
      row_pend_q   <= row_pend_d;
      complete_q   <= complete_d;
      de_q         <= de_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      last_q       <= last_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign O_wr_en      = wr_en_q;
  assign O_wr_addr    = wr_addr_q;
  assign O_wr_data    = wr_data_q;
  assign O_frame_done = frame_done_q;
  assign O_dims_err   = dims_err_q;
  assign O_active     = (state_q == S_ACTIVE);

endmodule
`default_nettype wire

// File: tb/tb_frame_downsampler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_frame_downsampler
//  Function : Self-checking bench for frame_downsampler. Expected writes come
//             from floor-arithmetic sampling rules, not from accumulators.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_frame_downsampler;
  localparam int MAX_WIDTH  = 1920;
  localparam int MAX_HEIGHT = 1080;
  localparam int OUT_W      = 16;
  localparam int OUT_H      = 8;
  localparam int COLOR_W    = 24;
  localparam int AW         = $clog2(OUT_W*OUT_H);
`ifdef FRAME_DOWNSAMPLER_SERPENTINE_EN
  localparam bit SERP = 1'b1;
`else
  localparam bit SERP = 1'b0;
`endif

  logic                          clk = 1'b0;
  logic                          I_rst = 1'b1;
  logic                          I_rgb_de = 1'b0;
  logic [COLOR_W-1:0]            I_rgb_data = '0;
  logic                          I_new_row = 1'b0;
  logic                          I_new_frame = 1'b0;
  logic [$clog2(MAX_WIDTH)-1:0]  I_image_width = '0;
  logic [$clog2(MAX_HEIGHT)-1:0] I_image_height = '0;
  logic                          I_width_valid = 1'b0;
  logic                          I_height_valid = 1'b0;
  logic                          O_wr_en;
  logic [AW-1:0]                 O_wr_addr;
  logic [COLOR_W-1:0]            O_wr_data;
  logic                          O_frame_done;
  logic                          O_dims_err;
  logic                          O_active;

  frame_downsampler #(
    .MAX_WIDTH (MAX_WIDTH),
    .MAX_HEIGHT(MAX_HEIGHT),
    .OUT_W     (OUT_W),
    .OUT_H     (OUT_H),
    .COLOR_W   (COLOR_W)
  ) dut (
    .I_rgb_clk     (clk),
    .I_rst         (I_rst),
    .I_rgb_de      (I_rgb_de),
    .I_rgb_data    (I_rgb_data),
    .I_new_row     (I_new_row),
    .I_new_frame   (I_new_frame),
    .I_image_width (I_image_width),
    .I_image_height(I_image_height),
    .I_width_valid (I_width_valid),
    .I_height_valid(I_height_valid),
    .O_wr_en       (O_wr_en),
    .O_wr_addr     (O_wr_addr),
    .O_wr_data     (O_wr_data),
    .O_frame_done  (O_frame_done),
    .O_dims_err    (O_dims_err),
    .O_active      (O_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                 cyc;
    int                 addr;
    logic [COLOR_W-1:0] data;
  } wr_t;

  wr_t                exp_q[$];
  int                 fd_q[$];
  int                 cyc = 0;
  int                 n_cmp = 0;
  int                 n_err = 0;
  bit                 chk_on = 1'b0;
  bit                 in_rst = 1'b0;
  bit                 exp_err = 1'b0;
  bit                 exp_active = 1'b0;
  int                 frame_seq = 0;
  int                 seq_seen = 0;
  int                 cap_n = 0;
  int                 fd_cnt = 0;
  logic [AW-1:0]      cap_addr[256];
  logic [COLOR_W-1:0] cap_data[256];
  bit                 ew, efd;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Matrix address of output cell (k, j).
  function automatic int model_addr(input int k, input int j);
    if (SERP && (k % 2 == 1)) return k*OUT_W + (OUT_W - 1 - j);
    return k*OUT_W + j;
  endfunction

  // Per-cycle compare against the model's expected write/done schedule.
  always @(negedge clk) begin
    if (chk_on) begin
      if (seq_seen != frame_seq) begin
        seq_seen = frame_seq;
        cap_n    = 0;
        fd_cnt   = 0;
      end
      ew = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      chk("wr_en", 64'(O_wr_en), 64'(ew));
      if (ew) begin
        chk("wr_addr", 64'(O_wr_addr), 64'(exp_q[0].addr));
        chk("wr_data", 64'(O_wr_data), 64'(exp_q[0].data));
        void'(exp_q.pop_front());
      end
      if (O_wr_en === 1'b1 && cap_n < 256) begin
        cap_addr[cap_n] = O_wr_addr;
        cap_data[cap_n] = O_wr_data;
        cap_n++;
      end
      efd = (fd_q.size() > 0) && (fd_q[0] == cyc);
      chk("frame_done", 64'(O_frame_done), 64'(efd));
      if (efd) void'(fd_q.pop_front());
      if (O_frame_done === 1'b1) fd_cnt++;
      chk("dims_err", 64'(O_dims_err), 64'(exp_err));
      chk("active", 64'(O_active), 64'(exp_active));
      if (in_rst) begin
        chk("rst_addr", 64'(O_wr_addr), 64'd0);
        chk("rst_data", 64'(O_wr_data), 64'd0);
      end
    end
  end

  // Drive one frame; rows < H truncates, stop_after > 0 aborts after that many writes.
  task automatic drive_frame(input int W, input int H, input bit wv, input bit hv,
                             input bit rnd, input int rows, input int stop_after);
    bit accept;
    int k, j, nw;
    bit rhit, chit;
    accept = wv && hv && (W >= OUT_W) && (H >= OUT_H);
    nw = 0;
    frame_seq++;
    I_image_width  = W[$clog2(MAX_WIDTH)-1:0];
    I_image_height = H[$clog2(MAX_HEIGHT)-1:0];
    I_width_valid  = wv;
    I_height_valid = hv;
    I_new_frame    = 1'b1;
    I_rgb_de       = ($urandom_range(0, 1) == 1);  // must be ignored
    I_rgb_data     = COLOR_W'($urandom);
    tick();
    I_new_frame = 1'b0;
    I_rgb_de    = 1'b0;
    exp_err     = ~accept;
    exp_active  = accept;
    for (int y = 0; y < rows; y++) begin
      I_new_row = 1'b1;
      tick();
      I_new_row = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
      k    = (y*OUT_H) / H;
      rhit = (((y+1)*OUT_H) / H) != k;
      for (int x = 0; x < W; x++) begin
        I_rgb_de   = 1'b1;
        I_rgb_data = rnd ? COLOR_W'($urandom) : {12'(y), 12'(x)};
        j    = (x*OUT_W) / W;
        chit = (((x+1)*OUT_W) / W) != j;
        if (accept && rhit && chit) begin
          exp_q.push_back('{cyc + 1, model_addr(k, j), I_rgb_data});
          nw++;
          if (k == OUT_H-1 && j == OUT_W-1) fd_q.push_back(cyc + 2);
        end
        tick();
        if (stop_after > 0 && nw >= stop_after) begin
          I_rgb_de   = 1'b0;
          I_rgb_data = '0;
          return;
        end
      end
      I_rgb_de   = 1'b0;
      I_rgb_data = '0;
      repeat ($urandom_range(1, 3)) tick();
    end
    repeat (4) tick();
  endtask

  initial begin
    // Reset state
    tick();
    chk_on = 1'b1;
    in_rst = 1'b1;
    repeat (3) tick();
    I_rst = 1'b0;
    tick();
    in_rst = 1'b0;
    repeat (2) tick();

    // 32x16 -> odd x on odd rows
    drive_frame(32, 16, 1, 1, 0, 16, 0);
    chk("t1_count", 64'(cap_n), 64'd128);
    chk("t1_first_data", 64'(cap_data[0]), 64'h001001);
    chk("t1_first_addr", 64'(cap_addr[0]), 64'd0);
    chk("t1_last_addr", 64'(cap_addr[127]), SERP ? 64'd112 : 64'd127);
    chk("t1_last_data", 64'(cap_data[127]), 64'h00F01F);
    chk("t1_done_cnt", 64'(fd_cnt), 64'd1);

    // 16x8 -> every pixel
    drive_frame(16, 8, 1, 1, 0, 8, 0);
    chk("t2_count", 64'(cap_n), 64'd128);
    chk("t2_r1x0_data", 64'(cap_data[16]), 64'h001000);
    chk("t2_r1x0_addr", 64'(cap_addr[16]), SERP ? 64'd31 : 64'd16);
    chk("t2_r1x15_addr", 64'(cap_addr[31]), SERP ? 64'd16 : 64'd31);
    chk("t2_r0x5_addr", 64'(cap_addr[5]), 64'd5);
    chk("t2_last_data", 64'(cap_data[127]), 64'h00700F);

    // 24x8 -> x = 1,2,4,5,...
    drive_frame(24, 8, 1, 1, 0, 8, 0);
    chk("t3_count", 64'(cap_n), 64'd128);
    chk("t3_x0", 64'(cap_data[0][11:0]), 64'd1);
    chk("t3_x1", 64'(cap_data[1][11:0]), 64'd2);
    chk("t3_x2", 64'(cap_data[2][11:0]), 64'd4);
    chk("t3_x3", 64'(cap_data[3][11:0]), 64'd5);
    chk("t3_x15", 64'(cap_data[15][11:0]), 64'd23);

    // Rejected dimensions, then recovery
    drive_frame(32, 16, 0, 1, 1, 16, 0);
    chk("t4_nowrite_inv", 64'(cap_n), 64'd0);
    drive_frame(10, 16, 1, 1, 1, 16, 0);
    chk("t4_nowrite_narrow", 64'(cap_n), 64'd0);
    chk("t4_no_done", 64'(fd_cnt), 64'd0);
    drive_frame(32, 16, 1, 1, 1, 16, 0);
    chk("t4_recover_cnt", 64'(cap_n), 64'd128);

    // Reset after 40 writes, then a clean frame
    drive_frame(32, 16, 1, 1, 0, 16, 40);
    I_rst = 1'b1;
    tick();
    in_rst     = 1'b1;
    exp_err    = 1'b0;
    exp_active = 1'b0;
    repeat (3) tick();
    I_rst = 1'b0;
    tick();
    in_rst = 1'b0;
    repeat (2) tick();
    chk("t5_partial_cnt", 64'(cap_n), 64'd40);
    chk("t5_partial_done", 64'(fd_cnt), 64'd0);
    drive_frame(32, 16, 1, 1, 0, 16, 0);
    chk("t5_restart_addr", 64'(cap_addr[0]), 64'd0);
    chk("t5_restart_cnt", 64'(cap_n), 64'd128);
    chk("t5_restart_done", 64'(fd_cnt), 64'd1);

    // Randomized frames, some truncated or rejected
    for (int i = 0; i < 10; i++) begin
      int w, h, r;
      w = $urandom_range(12, 40);
      h = $urandom_range(6, 20);
      r = ($urandom_range(0, 3) == 0) ? $urandom_range(1, h) : h;
      drive_frame(w, h, ($urandom_range(0, 5) != 0), 1'b1, 1'b1, r, 0);
    end

    repeat (4) tick();
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    chk("fd_q_drained", 64'(fd_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
